// File: rtl/i2c_ctrl_pkg.sv
// i2c_ctrl_pkg: shared types and constants for the I2C register controller.
//   ctrl_state_t   : transaction sequencer states
//   I2C_SLAVE_ADDR : 7-bit device address matched by the upstream I2C_slave
//   BYTE_W         : register / data byte width
`timescale 1ns/1ps
package i2c_ctrl_pkg;

    localparam logic [6:0] I2C_SLAVE_ADDR = 7'h49;
    localparam int         BYTE_W         = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GET_PTR = 2'd1,
        WR_DATA = 2'd2,
        RD_DATA = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: NUM_REGS x BYTE_W register storage with read-only masking.
//   clock, reset  : system clock, async active-high reset
//   wr_en_i       : write request at wr_idx_i (dropped if that reg is read-only)
//   wr_idx_i      : write index
//   wr_data_i     : write data
//   wr_ack_o      : write request hits a writable register (combinational)
//   rd_idx_i      : read index
//   rd_data_o     : status byte for read-only regs, stored byte otherwise
//   status_i      : live read-only values, byte i = [8*i +: 8]
//   regs_o        : stored register contents, byte i = [8*i +: 8]
`timescale 1ns/1ps
module i2c_reg_bank
    import i2c_ctrl_pkg::*;
#(
    parameter int                  NUM_REGS = 16,
    parameter int                  PTR_W    = $clog2(NUM_REGS),
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en_i,
    input  logic [PTR_W-1:0]           wr_idx_i,
    input  logic [BYTE_W-1:0]          wr_data_i,
    output logic                       wr_ack_o,
    input  logic [PTR_W-1:0]           rd_idx_i,
    output logic [BYTE_W-1:0]          rd_data_o,
    input  logic [BYTE_W*NUM_REGS-1:0] status_i,
    output logic [BYTE_W*NUM_REGS-1:0] regs_o
);

    logic [NUM_REGS-1:0][BYTE_W-1:0] regs_q;
    logic [NUM_REGS-1:0][BYTE_W-1:0] status_b;

    assign status_b = status_i;
    assign regs_o   = regs_q;

    // Read-only registers never take master data; their storage stays at reset value.
    assign wr_ack_o = wr_en_i & ~RO_MASK[wr_idx_i];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regs_q <= '0;
        end else if (wr_ack_o) begin
            regs_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = RO_MASK[rd_idx_i] ? status_b[rd_idx_i] : regs_q[rd_idx_i];

endmodule

// File: rtl/i2c_reg_controller.sv
// i2c_reg_controller: maps the byte stream of an I2C slave onto a register bank.
// First byte of a write transaction sets the register pointer, following bytes
// write at the pointer with auto-increment; reads stream from the pointer.
//   clock, reset  : system clock, async active-high reset
//   slv_start     : START / repeated START with address match (slv_rw valid)
//   slv_rw        : 1 = master reads
//   slv_stop      : STOP seen
//   slv_rx_valid  : received byte strobe, slv_rx_data
//   slv_tx_req    : slave wants next byte; answered by slv_tx_valid one cycle later
//   slv_tx_data   : byte to transmit, held until the next request
//   status_in     : live values for read-only registers
//   reg_q         : register contents
//   reg_wr_stb    : register written by master, index in reg_wr_idx
`timescale 1ns/1ps
module i2c_reg_controller
    import i2c_ctrl_pkg::*;
#(
    parameter int                  NUM_REGS = 16,
    parameter int                  PTR_W    = $clog2(NUM_REGS),
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       slv_start,
    input  logic                       slv_rw,
    input  logic                       slv_stop,
    input  logic                       slv_rx_valid,
    input  logic [BYTE_W-1:0]          slv_rx_data,
    input  logic                       slv_tx_req,
    output logic [BYTE_W-1:0]          slv_tx_data,
    output logic                       slv_tx_valid,
    input  logic [BYTE_W*NUM_REGS-1:0] status_in,
    output logic [BYTE_W*NUM_REGS-1:0] reg_q,
    output logic                       reg_wr_stb,
    output logic [PTR_W-1:0]           reg_wr_idx
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REGS - 1);

    ctrl_state_t       state_q;
    logic [PTR_W-1:0]  ptr_q;
    logic [BYTE_W-1:0] tx_data_q;
    logic              tx_valid_q;
    logic              wr_stb_q;
    logic [PTR_W-1:0]  wr_idx_q;

    logic [PTR_W-1:0]  ptr_inc_d;
    logic [PTR_W-1:0]  ptr_set_d;
    logic              wr_req;
    logic              wr_ack;
    logic [BYTE_W-1:0] rd_data;

    // Explicit wrap so non-power-of-two bank sizes also roll over to 0.
    assign ptr_inc_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    // Out-of-range pointer bytes clamp to the last register.
    assign ptr_set_d = ({1'b0, slv_rx_data} < 9'(NUM_REGS)) ? slv_rx_data[PTR_W-1:0] : PTR_LAST;

    // Uses the pre-START state, so a byte coincident with a new START is still written.
    assign wr_req = (state_q == WR_DATA) && slv_rx_valid;

    i2c_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .PTR_W    (PTR_W),
        .RO_MASK  (RO_MASK)
    ) u_bank (
        .clock     (clock),
        .reset     (reset),
        .wr_en_i   (wr_req),
        .wr_idx_i  (ptr_q),
        .wr_data_i (slv_rx_data),
        .wr_ack_o  (wr_ack),
        .rd_idx_i  (ptr_q),
        .rd_data_o (rd_data),
        .status_i  (status_in),
        .regs_o    (reg_q)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            wr_stb_q   <= 1'b0;
            wr_idx_q   <= '0;
        end else begin
            tx_valid_q <= 1'b0;
            wr_stb_q   <= 1'b0;

            // Byte / request handling in the current transaction.
            case (state_q)
                GET_PTR: begin
                    if (slv_rx_valid) begin
                        ptr_q   <= ptr_set_d;
                        state_q <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (slv_rx_valid) begin
                        ptr_q <= ptr_inc_d;
                        if (wr_ack) begin
                            wr_stb_q <= 1'b1;
                            wr_idx_q <= ptr_q;
                        end
                    end
                end
                RD_DATA: begin
                    if (slv_tx_req) begin
                        tx_data_q  <= rd_data;
                        tx_valid_q <= 1'b1;
                        ptr_q      <= ptr_inc_d;
                    end
                end
                default: ;
            endcase

            // Bus events override the state chosen above; START beats STOP.
            if (slv_stop) begin
                state_q <= IDLE;
            end
            if (slv_start) begin
                state_q <= slv_rw ? RD_DATA : GET_PTR;
            end
        end
    end

    assign slv_tx_data  = tx_data_q;
    assign slv_tx_valid = tx_valid_q;
    assign reg_wr_stb   = wr_stb_q;
    assign reg_wr_idx   = wr_idx_q;

endmodule

// File: tb/tb_i2c_reg_controller.sv
`timescale 1ns/1ps
module tb_i2c_reg_controller;

    localparam int NUM_REGS = 16;
    localparam int PTR_W    = 4;

    typedef struct {
        int       idx;
        logic [7:0] data;
    } wr_exp_t;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic                    slv_start = 1'b0;
    logic                    slv_rw = 1'b0;
    logic                    slv_stop = 1'b0;
    logic                    slv_rx_valid = 1'b0;
    logic [7:0]              slv_rx_data = 8'h00;
    logic                    slv_tx_req = 1'b0;
    logic [7:0]              slv_tx_data;
    logic                    slv_tx_valid;
    logic [8*NUM_REGS-1:0]   status_in = '0;
    logic [8*NUM_REGS-1:0]   reg_q;
    logic                    reg_wr_stb;
    logic [PTR_W-1:0]        reg_wr_idx;

    int passed = 0;
    int total  = 0;

    wr_exp_t    wr_q[$];
    logic [7:0] tx_q[$];

    always #5 clock = ~clock;

    i2c_reg_controller #(
        .NUM_REGS (NUM_REGS),
        .RO_MASK  (16'h0020)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .slv_start    (slv_start),
        .slv_rw       (slv_rw),
        .slv_stop     (slv_stop),
        .slv_rx_valid (slv_rx_valid),
        .slv_rx_data  (slv_rx_data),
        .slv_tx_req   (slv_tx_req),
        .slv_tx_data  (slv_tx_data),
        .slv_tx_valid (slv_tx_valid),
        .status_in    (status_in),
        .reg_q        (reg_q),
        .reg_wr_stb   (reg_wr_stb),
        .reg_wr_idx   (reg_wr_idx)
    );

    // Scoreboard: every write strobe / tx pulse must match the next expected entry.
    always @(negedge clock) begin
        if (!reset) begin
            if (reg_wr_stb) begin
                total++;
                if (wr_q.size() == 0) begin
                    $display("FAIL unexpected_wr: idx=%0d data=%h, expected no write", reg_wr_idx, reg_q[8*reg_wr_idx +: 8]);
                end else begin
                    wr_exp_t e;
                    e = wr_q.pop_front();
                    if (reg_wr_idx !== PTR_W'(e.idx) || reg_q[8*e.idx +: 8] !== e.data)
                        $display("FAIL wr_sb: idx=%0d data=%h, expected idx=%0d data=%h",
                                 reg_wr_idx, reg_q[8*e.idx +: 8], e.idx, e.data);
                    else
                        passed++;
                end
            end
            if (slv_tx_valid) begin
                total++;
                if (tx_q.size() == 0) begin
                    $display("FAIL unexpected_tx: data=%h, expected no tx", slv_tx_data);
                end else begin
                    logic [7:0] t;
                    t = tx_q.pop_front();
                    if (slv_tx_data !== t)
                        $display("FAIL tx_sb: data=%h, expected %h", slv_tx_data, t);
                    else
                        passed++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- drivers ----------------
    task automatic do_start(input logic rw);
        @(negedge clock); slv_start = 1'b1; slv_rw = rw;
        @(negedge clock); slv_start = 1'b0;
    endtask

    task automatic do_stop();
        @(negedge clock); slv_stop = 1'b1;
        @(negedge clock); slv_stop = 1'b0;
    endtask

    task automatic do_rx(input logic [7:0] d);
        @(negedge clock); slv_rx_valid = 1'b1; slv_rx_data = d;
        @(negedge clock); slv_rx_valid = 1'b0;
    endtask

    task automatic do_wr(input int idx, input logic [7:0] d);
        wr_exp_t e;
        e.idx = idx; e.data = d;
        wr_q.push_back(e);
        do_rx(d);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clock);
        total++; if (slv_tx_valid !== 1'b0) $display("FAIL rst_tx_valid: %b expected 0", slv_tx_valid); else passed++;
        total++; if (slv_tx_data !== 8'h00) $display("FAIL rst_tx_data: %h expected 00", slv_tx_data); else passed++;
        total++; if (reg_wr_stb !== 1'b0) $display("FAIL rst_wr_stb: %b expected 0", reg_wr_stb); else passed++;
        total++; if (reg_wr_idx !== '0) $display("FAIL rst_wr_idx: %h expected 0", reg_wr_idx); else passed++;
        total++; if (reg_q !== '0) $display("FAIL rst_regs: %h expected 0", reg_q); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_write_basic();
        int n0;
        n0 = wr_q.size();
        do_start(1'b0);
        do_rx(8'h03);
        do_wr(3, 8'hA5);
        do_stop();
        // IDLE after STOP: a stray byte must not write anything.
        do_rx(8'h77);
        total++; if (reg_q[8*3 +: 8] !== 8'hA5) $display("FAIL basic_reg3: %h expected a5", reg_q[8*3 +: 8]); else passed++;
        total++; if (wr_q.size() !== n0) $display("FAIL basic_pending: %0d expected %0d", wr_q.size(), n0); else passed++;
    endtask

    task automatic test_write_wrap();
        do_start(1'b0);
        do_rx(8'h0E);
        do_wr(14, 8'h11);
        do_wr(15, 8'h22);
        do_wr(0,  8'h33);
        do_stop();
        total++; if (reg_q[8*0 +: 8] !== 8'h33) $display("FAIL wrap_reg0: %h expected 33", reg_q[7:0]); else passed++;
    endtask

    task automatic test_clamp();
        do_start(1'b0);
        do_rx(8'hC8);
        do_wr(15, 8'h5A);
        do_wr(0,  8'h6B);
        do_stop();
    endtask

    task automatic test_read_after_ptr();
        logic [7:0] exp_d[3];
        exp_d[0] = 8'h21; exp_d[1] = 8'h31; exp_d[2] = 8'h41;
        do_start(1'b0);
        do_rx(8'h02);
        for (int i = 0; i < 3; i++) do_wr(2 + i, exp_d[i]);
        do_stop();
        do_start(1'b0);
        do_rx(8'h02);
        do_start(1'b1);
        for (int i = 0; i < 3; i++) begin
            tx_q.push_back(exp_d[i]);
            @(negedge clock); slv_tx_req = 1'b1;
            @(negedge clock); slv_tx_req = 1'b0;
            total++;
            if (slv_tx_valid !== 1'b1) $display("FAIL rd_latency%0d: valid=%b expected 1", i, slv_tx_valid); else passed++;
        end
        @(negedge clock);
        total++; if (slv_tx_valid !== 1'b0) $display("FAIL rd_pulse: valid=%b expected 0", slv_tx_valid); else passed++;
        total++; if (slv_tx_data !== 8'h41) $display("FAIL rd_hold: %h expected 41", slv_tx_data); else passed++;
        do_stop();
    endtask

    task automatic test_ro();
        status_in[8*5 +: 8] = 8'h5C;
        do_start(1'b0);
        do_rx(8'h05);
        do_rx(8'hFF);       // read-only: dropped, no strobe, pointer still moves
        do_wr(6, 8'h66);
        do_stop();
        total++; if (reg_q[8*5 +: 8] !== 8'h00) $display("FAIL ro_store: %h expected 00", reg_q[8*5 +: 8]); else passed++;
        do_start(1'b0);
        do_rx(8'h05);
        do_start(1'b1);
        tx_q.push_back(8'h5C);
        @(negedge clock); slv_tx_req = 1'b1;
        @(negedge clock); slv_tx_req = 1'b0;
        tx_q.push_back(8'h66);
        @(negedge clock); slv_tx_req = 1'b1;
        @(negedge clock); slv_tx_req = 1'b0;
        // Byte arriving during a read is ignored.
        do_rx(8'hEE);
        do_stop();
    endtask

    task automatic test_rx_stop_same_cycle();
        do_start(1'b0);
        do_rx(8'h08);
        wr_q.push_back('{idx: 8, data: 8'h99});
        @(negedge clock); slv_rx_valid = 1'b1; slv_rx_data = 8'h99; slv_stop = 1'b1;
        @(negedge clock); slv_rx_valid = 1'b0; slv_stop = 1'b0;
        do_rx(8'hAB);
        total++; if (reg_q[8*8 +: 8] !== 8'h99) $display("FAIL rxstop_reg8: %h expected 99", reg_q[8*8 +: 8]); else passed++;
        total++; if (reg_q[8*9 +: 8] !== 8'h00) $display("FAIL rxstop_reg9: %h expected 00", reg_q[8*9 +: 8]); else passed++;
    endtask

    task automatic test_tx_req_ignored();
        @(negedge clock); slv_tx_req = 1'b1;
        @(negedge clock); slv_tx_req = 1'b0;
        total++; if (slv_tx_valid !== 1'b0) $display("FAIL txreq_idle: valid=%b expected 0", slv_tx_valid); else passed++;
        do_start(1'b0);
        @(negedge clock); slv_tx_req = 1'b1;
        @(negedge clock); slv_tx_req = 1'b0;
        total++; if (slv_tx_valid !== 1'b0) $display("FAIL txreq_getptr: valid=%b expected 0", slv_tx_valid); else passed++;
        do_stop();
    endtask

    task automatic test_reset_mid();
        do_start(1'b0);
        do_rx(8'h01);
        do_wr(1, 8'h10);
        @(negedge clock); slv_rx_valid = 1'b1; slv_rx_data = 8'h20;
        #2 reset = 1'b1;
        #1 slv_rx_valid = 1'b0;
        total++; if (reg_q !== '0) $display("FAIL midrst_regs: %h expected 0", reg_q); else passed++;
        total++; if (slv_tx_data !== 8'h00) $display("FAIL midrst_tx_data: %h expected 00", slv_tx_data); else passed++;
        total++; if (reg_wr_idx !== '0) $display("FAIL midrst_wr_idx: %h expected 0", reg_wr_idx); else passed++;
        @(negedge clock); reset = 1'b0;
        // Back in IDLE: stray byte does nothing.
        do_rx(8'h44);
        do_start(1'b1);
        tx_q.push_back(8'h00);
        @(negedge clock); slv_tx_req = 1'b1;
        @(negedge clock); slv_tx_req = 1'b0;
        total++; if (slv_tx_valid !== 1'b1) $display("FAIL midrst_rd_valid: %b expected 1", slv_tx_valid); else passed++;
        do_stop();
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_write_wrap();
        test_clamp();
        test_read_after_ptr();
        test_ro();
        test_rx_stop_same_cycle();
        test_tx_req_ignored();
        test_reset_mid();
        repeat (3) @(negedge clock);
        total++; if (wr_q.size() != 0) $display("FAIL missing_wr: %0d pending expected 0", wr_q.size()); else passed++;
        total++; if (tx_q.size() != 0) $display("FAIL missing_tx: %0d pending expected 0", tx_q.size()); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
